// File: rtl/gpu_mem_arbiter.sv
// Round-robin arbiter and responder between the per-thread LSUs and a single-port synchronous data memory.
// Latency: a request accepted in cycle T drives mem_en in T+1 and resp_valid in T+3.
//          The next request can be accepted no earlier than T+4.
// Backpressure: the one-hot req_ready strobe is the only handshake. A requester holds its request until it sees req_ready.
//               Only one transaction is in flight at a time.
//
// Ports:
//   clk, reset                  rising-edge clock; synchronous active-high reset
//   req_valid/we/addr/wdata     per-channel requests (addr/wdata packed, ch i at [i*W +: W])
//   req_ready                   one-hot accept strobe (combinational, IDLE only)
//   resp_valid, resp_rdata      one-hot 1-cycle response strobe; shared load data
//   mem_en/we/addr/wdata/rdata  synchronous memory port (read data one cycle after mem_en)
//   busy, served_count          transaction in flight; saturating completed-transaction count
module gpu_mem_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CHANNELS-1:0]            req_valid,
    input  logic [NUM_CHANNELS-1:0]            req_we,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_CHANNELS-1:0]            req_ready,
    output logic [NUM_CHANNELS-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]              resp_rdata,
    output logic                               mem_en,
    output logic                               mem_we,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic [DATA_WIDTH-1:0]              mem_wdata,
    input  logic [DATA_WIDTH-1:0]              mem_rdata,
    output logic                               busy,
    output logic [15:0]                        served_count
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [NUM_CHANNELS-1:0] CH_ONE = NUM_CHANNELS'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                  state;
    logic [CH_W-1:0]         rr_ptr;
    logic [CH_W-1:0]         lat_ch;
    logic                    lat_we;

    logic                    grant_found;
    logic [CH_W-1:0]         grant_idx;
    logic [CH_W-1:0]         cand;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [15:0]             served_next;

    // Round-robin search. The search starts just after the last granted channel, so rr_ptr
    // itself has the lowest priority. Lowest offset wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            cand = CH_W'((int'(rr_ptr) + k) % NUM_CHANNELS);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_we    = req_we[grant_idx];
        sel_addr  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // Same-cycle accept: the requester can drop its request right after this strobe.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready = CH_ONE << grant_idx;
        end
    end

    // The count advances on the edge that raises resp_valid, so it already includes the
    // transaction being reported.
    always_comb begin
        served_next = served_count;
        if (state == CAPTURE && served_count != 16'hFFFF) begin
            served_next = served_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= CH_W'(NUM_CHANNELS - 1);
            lat_ch       <= '0;
            lat_we       <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            resp_valid   <= '0;
            resp_rdata   <= '0;
            busy         <= 1'b0;
            served_count <= 16'd0;
        end else begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            resp_valid   <= '0;
            served_count <= served_next;

            case (state)
                IDLE: begin
                    if (grant_found) begin
                        rr_ptr    <= grant_idx;
                        lat_ch    <= grant_idx;
                        lat_we    <= sel_we;
                        // The memory port is driven straight from the registered request.
                        // mem_addr and mem_wdata keep their values afterwards. Only mem_en and mem_we qualify them.
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    // A store leaves the last load data visible on resp_rdata.
                    if (!lat_we) begin
                        resp_rdata <= mem_rdata;
                    end
                    resp_valid <= CH_ONE << lat_ch;
                    state      <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed bench for gpu_mem_arbiter with a scoreboard on the response side.
// Latency: not applicable (bench).
// Backpressure: the stimulus holds each request until its req_ready strobe is sampled.
module tb_gpu_mem_arbiter;

    localparam int NC = 4;
    localparam int DW = 8;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NC-1:0]     req_valid = '0;
    logic [NC-1:0]     req_we = '0;
    logic [NC*AW-1:0]  req_addr = '0;
    logic [NC*DW-1:0]  req_wdata = '0;
    logic [NC-1:0]     req_ready;
    logic [NC-1:0]     resp_valid;
    logic [DW-1:0]     resp_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic              busy;
    logic [15:0]       served_count;

    gpu_mem_arbiter #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .served_count (served_count)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory model.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected responses in hand-computed grant order.
    typedef struct packed {
        logic [NC-1:0] vld;
        logic [DW-1:0] rdata;
    } resp_t;
    resp_t exp_q[$];

    task automatic expect_resp(input int ch, input logic [DW-1:0] rdata);
        resp_t r;
        r.vld   = NC'(1) << ch;
        r.rdata = rdata;
        exp_q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (!reset && resp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'(resp_valid), 32'(0));
            end else begin
                resp_t r;
                r = exp_q.pop_front();
                check("resp_valid", 32'(resp_valid), 32'(r.vld));
                check("resp_rdata", 32'(resp_rdata), 32'(r.rdata));
            end
        end
    end

    // Grant log recorded by the stimulus side.
    int g_ch[$];
    int g_cyc[$];

    task automatic post(input int ch, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_we[ch]               = we;
        req_addr[ch*AW +: AW]    = addr;
        req_wdata[ch*DW +: DW]   = wdata;
        req_valid[ch]            = 1'b1;
    endtask

    // One cycle: sample the handshake mid-cycle, then withdraw the accepted requests after the edge.
    task automatic step();
        logic [NC-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        if (acc != '0) begin
            check("grant_onehot", 32'($onehot(acc)), 32'(1));
            for (int i = 0; i < NC; i++) begin
                if (acc[i]) begin
                    g_ch.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((req_valid != '0 || busy) && n < budget);
        check("idle_reached", 32'({busy, req_valid}), 32'(0));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_grants(input string name, input int exp_ch[4], input int n);
        check({name, "_count"}, 32'(g_ch.size()), 32'(n));
        for (int i = 0; i < n && i < g_ch.size(); i++) begin
            check({name, "_order"}, 32'(g_ch[i]), 32'(exp_ch[i]));
        end
        g_ch.delete();
        g_cyc.delete();
    endtask

    initial begin
        int order[4];
        for (int i = 0; i < 32; i++) mem[i] = DW'(i + 1);
        do_reset();

        // Reset state.
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_mem_en", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_served", 32'(served_count), 32'(0));
        check("rst_rdata", 32'(resp_rdata), 32'(0));
        @(posedge clk);
        #1;

        // 1: single load, cycle-exact latency.
        expect_resp(0, 8'd1);
        post(0, 1'b0, 5'd0, 8'd0);
        @(negedge clk);
        check("t1_ready_T", 32'(req_ready), 32'(4'b0001));
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("t1_mem_en_T1", 32'({mem_en, mem_we}), 32'(2'b10));
        check("t1_mem_addr", 32'(mem_addr), 32'(0));
        check("t1_busy", 32'(busy), 32'(1));
        @(negedge clk);
        check("t1_no_resp_T2", 32'({mem_en, resp_valid}), 32'(0));
        @(negedge clk);
        check("t1_resp_T3", 32'(resp_valid), 32'(4'b0001));
        check("t1_rdata_T3", 32'(resp_rdata), 32'(1));
        @(negedge clk);
        check("t1_idle_T4", 32'(busy), 32'(0));
        check("t1_served", 32'(served_count), 32'(1));
        @(posedge clk);
        #1;
        g_ch.delete();
        g_cyc.delete();

        // 2: all four channels at once, after a fresh reset.
        do_reset();
        for (int i = 0; i < NC; i++) begin
            expect_resp(i, DW'(i + 1));
            post(i, 1'b0, AW'(i), 8'd0);
        end
        wait_idle(60);
        for (int i = 1; i < g_cyc.size(); i++) begin
            check("t2_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(4));
        end
        order = '{0, 1, 2, 3};
        check_grants("t2_grant", order, 4);
        check("t2_served", 32'(served_count), 32'(4));

        // 3: store then load on ch2. The store ack keeps the previous load data (4).
        expect_resp(2, 8'd4);
        post(2, 1'b1, 5'd18, 8'd10);
        step();
        check("t3_write_cycle", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 5'd18, 8'd10}));
        wait_idle(20);
        expect_resp(2, 8'd10);
        post(2, 1'b0, 5'd18, 8'd0);
        wait_idle(20);
        g_ch.delete();
        g_cyc.delete();

        // 4: wrap-around. ch3 is served, then ch0 and ch3 request together, and ch0 goes first.
        expect_resp(3, 8'd4);
        post(3, 1'b0, 5'd3, 8'd0);
        wait_idle(20);
        expect_resp(0, 8'd1);
        expect_resp(3, 8'd2);
        post(0, 1'b0, 5'd0, 8'd0);
        post(3, 1'b0, 5'd1, 8'd0);
        wait_idle(40);
        order = '{3, 0, 3, 0};
        check_grants("t4_grant", order, 3);

        // 5: reset while ch0's load is in CAPTURE. The response is dropped.
        post(0, 1'b0, 5'd2, 8'd0);
        step();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_no_resp", 32'(resp_valid), 32'(0));
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_served", 32'(served_count), 32'(0));
        @(posedge clk);
        #1;
        g_ch.delete();
        g_cyc.delete();
        expect_resp(0, 8'd3);
        expect_resp(1, 8'd4);
        post(1, 1'b0, 5'd3, 8'd0);
        post(0, 1'b0, 5'd2, 8'd0);
        wait_idle(40);
        order = '{0, 1, 0, 0};
        check_grants("t5_grant", order, 2);

        // 6: saturation from FFFE.
        force dut.served_count = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.served_count;
        @(negedge clk);
        check("t6_preload", 32'(served_count), 32'(16'hFFFE));
        @(posedge clk);
        #1;
        expect_resp(1, 8'd1);
        post(1, 1'b0, 5'd0, 8'd0);
        wait_idle(20);
        check("t6_ffff", 32'(served_count), 32'(16'hFFFF));
        expect_resp(1, 8'd1);
        post(1, 1'b0, 5'd0, 8'd0);
        wait_idle(20);
        check("t6_saturate", 32'(served_count), 32'(16'hFFFF));

        repeat (3) @(posedge clk);
        check("exp_queue_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
